// File: rtl/regfile_issue_ctrl_if.sv
// Instruction channel plus register-file read/write bus between the issue controller and its neighbours.
// master = controller side; slave = instruction source and register file.
interface regfile_issue_ctrl_if #(
   parameter int SRCSIZE = 2
);
   localparam int INSTRW = 2 + 3*SRCSIZE;

   logic                instr_valid;
   logic                instr_ready;
   logic [INSTRW-1:0]   instr;
   logic [SRCSIZE-1:0]  rf_src1;
   logic [SRCSIZE-1:0]  rf_src2;
   logic [7:0]          rf_regA;
   logic [7:0]          rf_regB;
   logic [SRCSIZE-1:0]  rf_dst;
   logic [7:0]          rf_data;
   logic                rf_write;

   modport master (
      input  instr_valid, instr, rf_regA, rf_regB,
      output instr_ready, rf_src1, rf_src2, rf_dst, rf_data, rf_write
   );

   modport slave (
      output instr_valid, instr, rf_regA, rf_regB,
      input  instr_ready, rf_src1, rf_src2, rf_dst, rf_data, rf_write
   );
endinterface

// File: rtl/regfile_issue_ctrl.sv
// Register-file issue controller: IDLE->READ->EXEC->WB, accept to write strobe 3 cycles, one instruction per 4 cycles.
// instr_ready is low while an instruction is in flight; optional STATUS_FLAGS_EN adds flag_z/flag_c.
module regfile_issue_ctrl #(
   parameter int SRCSIZE  = 2,
   parameter int ZERO_REG = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_issue_ctrl_if.master bus,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           retired
`ifdef STATUS_FLAGS_EN
   ,
   output logic                 flag_z,
   output logic                 flag_c
`endif
);
   localparam int INSTRW = 2 + 3*SRCSIZE;
   localparam logic [SRCSIZE-1:0] ZREG = SRCSIZE'(ZERO_REG);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                accept;
   logic [INSTRW-1:0]   instr_q;
   logic [7:0]          op_a;
   logic [7:0]          op_b;
   logic [7:0]          result;
   logic [7:0]          alu_res;

   logic [1:0]          op;
   logic [SRCSIZE-1:0]  dst;
   logic [SRCSIZE-1:0]  src1;
   logic [SRCSIZE-1:0]  src2;

   assign op   = instr_q[INSTRW-1 -: 2];
   assign dst  = instr_q[3*SRCSIZE-1 -: SRCSIZE];
   assign src1 = instr_q[2*SRCSIZE-1 -: SRCSIZE];
   assign src2 = instr_q[SRCSIZE-1:0];

   // Addresses and write data come straight from registers, so every bus output is registered.
   assign bus.rf_src1 = src1;
   assign bus.rf_src2 = src2;
   assign bus.rf_dst  = dst;
   assign bus.rf_data = result;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.instr_valid && bus.instr_ready) begin
               accept    = 1'b1;
               state_nxt = READ;
            end
         end
         READ:    state_nxt = EXEC;
         EXEC:    state_nxt = WB;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      alu_res = 8'd0;
      case (op)
         2'b00:   alu_res = op_a + op_b;
         2'b01:   alu_res = op_a - op_b;
         2'b10:   alu_res = op_a & op_b;
         default: alu_res = op_a;
      endcase
   end

`ifdef STATUS_FLAGS_EN
   logic [8:0] add_full;
   logic       alu_c;

   assign add_full = {1'b0, op_a} + {1'b0, op_b};

   always_comb begin
      alu_c = 1'b0;
      case (op)
         2'b00:   alu_c = add_full[8];
         2'b01:   alu_c = (op_a < op_b);
         default: alu_c = 1'b0;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         instr_q         <= '0;
         op_a            <= 8'd0;
         op_b            <= 8'd0;
         result          <= 8'd0;
         retired         <= 8'd0;
         busy            <= 1'b0;
         done            <= 1'b0;
         bus.instr_ready <= 1'b1;
         bus.rf_write    <= 1'b0;
`ifdef STATUS_FLAGS_EN
         flag_z          <= 1'b0;
         flag_c          <= 1'b0;
`endif
      end else begin
         state           <= state_nxt;
         bus.instr_ready <= (state_nxt == IDLE);
         busy            <= (state_nxt != IDLE);
         done            <= (state_nxt == WB);
         // Writes to the hard-wired zero register are dropped, but done still pulses.
         bus.rf_write    <= (state_nxt == WB) && (dst != ZREG);
         if (accept) begin
            instr_q <= bus.instr;
         end
         if (state == READ) begin
            op_a <= bus.rf_regA;
            op_b <= bus.rf_regB;
         end
         if (state == EXEC) begin
            result <= alu_res;
`ifdef STATUS_FLAGS_EN
            flag_z <= (alu_res == 8'd0);
            flag_c <= alu_c;
`endif
         end
         if (state == WB) begin
            retired <= retired + 8'd1;
         end
      end
   end
endmodule

// File: tb/tb_regfile_issue_ctrl.sv
// Bench for regfile_issue_ctrl: register-file environment, transaction-level model, per-cycle compare and directed literals.
module tb_regfile_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       reload;
   logic       busy;
   logic       done;
   logic [7:0] retired;
`ifdef STATUS_FLAGS_EN
   logic       flag_z;
   logic       flag_c;
`endif

   int vectors = 0;
   int errors  = 0;

   regfile_issue_ctrl_if #(.SRCSIZE(2)) bus ();

   regfile_issue_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .retired (retired)
`ifdef STATUS_FLAGS_EN
      ,
      .flag_z  (flag_z),
      .flag_c  (flag_c)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] init_val(input int i);
      case (i)
         0:       return 8'h10;
         1:       return 8'h05;
         2:       return 8'hF0;
         default: return 8'h00;
      endcase
   endfunction

   // Register file seen by the DUT.
   logic [7:0] rf_env [4];
   assign bus.rf_regA = rf_env[bus.rf_src1];
   assign bus.rf_regB = rf_env[bus.rf_src2];
   always @(posedge clk) begin
      if (reload) begin
         for (int i = 0; i < 4; i++) rf_env[i] <= init_val(i);
      end else if (bus.rf_write) begin
         rf_env[bus.rf_dst] <= bus.rf_data;
      end
   end

   function automatic logic [7:0] m_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      int s;
      case (op)
         2'b00:   s = int'(a) + int'(b);
         2'b01:   s = int'(a) - int'(b) + 256;
         2'b10:   s = int'(a & b);
         default: s = int'(a);
      endcase
      return 8'(s % 256);
   endfunction

   function automatic bit m_carry(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      if (op == 2'b00) return (int'(a) + int'(b)) > 255;
      if (op == 2'b01) return a < b;
      return 1'b0;
   endfunction

   // Transaction model: an accepted instruction occupies the three cycles after its handshake.
   logic [7:0] mrf [4];
   bit         started = 1'b0;
   bit         m_busy  = 1'b0;
   int         cyc     = 0;
   int         m_acc   = 0;
   logic [7:0] m_ret   = 8'd0;
   logic [1:0] e_dst, e_s1, e_s2;
   logic [7:0] e_res;
   bit         e_c, fz, fc;
   int         ph;
   assign ph = cyc - m_acc;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reload) begin
         for (int i = 0; i < 4; i++) mrf[i] <= init_val(i);
      end
      if (rst) begin
         started <= 1'b1;
         m_busy  <= 1'b0;
         m_ret   <= 8'd0;
         fz      <= 1'b0;
         fc      <= 1'b0;
      end else begin
         if (m_busy && ph == 3) begin
            m_busy <= 1'b0;
            m_ret  <= m_ret + 8'd1;
            if (e_dst != 2'd3) mrf[e_dst] <= e_res;
         end else if (!m_busy && started && bus.instr_valid) begin
            m_busy <= 1'b1;
            m_acc  <= cyc;
            e_dst  <= bus.instr[5:4];
            e_s1   <= bus.instr[3:2];
            e_s2   <= bus.instr[1:0];
            e_res  <= m_res(bus.instr[7:6], mrf[bus.instr[3:2]], mrf[bus.instr[1:0]]);
            e_c    <= m_carry(bus.instr[7:6], mrf[bus.instr[3:2]], mrf[bus.instr[1:0]]);
         end
         if (m_busy && ph == 2) begin
            fz <= (e_res == 8'd0);
            fc <= e_c;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         chk("instr_ready", bus.instr_ready, !m_busy);
         chk("busy", busy, m_busy);
         chk("done", done, m_busy && ph == 3);
         chk("rf_write", bus.rf_write, m_busy && ph == 3 && e_dst != 2'd3);
         chk("retired", retired, m_ret);
`ifdef STATUS_FLAGS_EN
         chk("flag_z", flag_z, fz);
         chk("flag_c", flag_c, fc);
`endif
         if (m_busy) begin
            chk("rf_src1", bus.rf_src1, e_s1);
            chk("rf_src2", bus.rf_src2, e_s2);
         end
         if (m_busy && ph == 3) begin
            chk("rf_dst", bus.rf_dst, e_dst);
            chk("rf_data", bus.rf_data, e_res);
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s1,
                        input logic [1:0] s2, input bit drop, output int acc_cyc);
      bit got;
      got = 1'b0;
      acc_cyc = -1;
      bus.instr_valid = 1'b1;
      bus.instr = {op, d, s1, s2};
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk);
         if (bus.instr_ready) begin
            got = 1'b1;
            acc_cyc = int'($time / 10);
         end
         #1;
      end
      if (drop) bus.instr_valid = 1'b0;
      if (!got) begin
         vectors++;
         errors++;
         $display("FAIL handshake: no acceptance within 20 cycles, instr 0x%0h", {op, d, s1, s2});
      end
   endtask

   int t1, t2;

   initial begin
      rst = 1'b1;
      reload = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reload = 1'b0;

      @(negedge clk);
      chk("reset instr_ready", bus.instr_ready, 1);
      chk("reset busy", busy, 0);
      chk("reset rf_write", bus.rf_write, 0);
      chk("reset retired", retired, 0);
      chk("reset rf_data", bus.rf_data, 0);

      // Payload without valid must be ignored.
      bus.instr = 8'hFF;
      repeat (3) @(posedge clk);
      #1 chk("idle while invalid", busy, 0);

      // ADD r2 = r0 + r1
      issue(2'b00, 2'd2, 2'd0, 2'd1, 1'b1, t1);
      @(negedge clk);
      chk("add src1", bus.rf_src1, 0);
      chk("add src2", bus.rf_src2, 1);
      repeat (2) @(negedge clk);
      chk("add rf_write", bus.rf_write, 1);
      chk("add rf_dst", bus.rf_dst, 2);
      chk("add rf_data", bus.rf_data, 8'h15);
      chk("add done", done, 1);
      @(negedge clk);
      chk("add ready after", bus.instr_ready, 1);
      chk("add retired", retired, 1);

      // SUB r1 = r1 - r0 wraps
      issue(2'b01, 2'd1, 2'd1, 2'd0, 1'b1, t1);
      repeat (3) @(negedge clk);
      chk("sub rf_data", bus.rf_data, 8'hF5);
      chk("sub rf_write", bus.rf_write, 1);
`ifdef STATUS_FLAGS_EN
      chk("sub flag_c", flag_c, 1);
      chk("sub flag_z", flag_z, 0);
`endif
      @(negedge clk);
      chk("sub retired", retired, 2);

      // MOV r3 = r0: zero register, no write strobe
      issue(2'b11, 2'd3, 2'd0, 2'd0, 1'b1, t1);
      repeat (3) @(negedge clk);
      chk("mov zr done", done, 1);
      chk("mov zr rf_write", bus.rf_write, 0);
      chk("mov zr rf_data", bus.rf_data, 8'h10);
      @(negedge clk);
      chk("mov zr retired", retired, 3);

      // Restore initial register contents for the dependent pair.
      reload = 1'b1;
      @(posedge clk);
      #1 reload = 1'b0;

      // ADD r2 = r0 + r1 then AND r0 = r2 & r2 with valid held.
      issue(2'b00, 2'd2, 2'd0, 2'd1, 1'b0, t1);
      issue(2'b10, 2'd0, 2'd2, 2'd2, 1'b1, t2);
      chk("dep accept spacing", t2 - t1, 4);
      repeat (3) @(negedge clk);
      chk("dep rf_data", bus.rf_data, 8'h15);
      chk("dep rf_dst", bus.rf_dst, 0);
      chk("dep rf_write", bus.rf_write, 1);
      @(negedge clk);

      // Reset while in EXEC discards the instruction.
      issue(2'b00, 2'd0, 2'd0, 2'd1, 1'b1, t1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst rf_write", bus.rf_write, 0);
      chk("midrst ready", bus.instr_ready, 1);
      chk("midrst busy", busy, 0);
      chk("midrst retired", retired, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst no write", bus.rf_write, 0);
      end

      // MOV r1 = r2 after reset still works.
      issue(2'b11, 2'd1, 2'd2, 2'd0, 1'b1, t1);
      repeat (3) @(negedge clk);
      chk("post rst rf_data", bus.rf_data, 8'h15);
      @(negedge clk);
      chk("post rst retired", retired, 1);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
